// File: rtl/z80_bus_responder.sv
// Z80 bus slave: decodes a memory or I/O window, stretches the CPU cycle with wait_n and forwards it to a req/ack backend.
// Optional interrupt acknowledge support is compiled in with `define Z80_RESP_INTACK_EN.
module z80_bus_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'h8000,
  parameter logic [15:0] ADDR_MASK  = 16'hC000,
  parameter bit          IS_IO      = 1'b0,
  parameter logic [7:0]  IRQ_VECTOR = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        wait_n,
  output logic        int_n,
  output logic        be_req,
  output logic        be_we,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack,
  input  logic        irq_in
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t     state;
  logic [7:0] dout_q;
  logic       space_n;
  logic       addr_match;
  logic       hit;
  logic       intack;
  logic       start;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    space_n    = IS_IO ? iorq_n : mreq_n;
    addr_match = IS_IO ? ((A[7:0] & ADDR_MASK[7:0]) == (BASE_ADDR[7:0] & ADDR_MASK[7:0]))
                       : ((A & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    hit        = !space_n && (!rd_n || !wr_n) && rfsh_n && (m1_n || !IS_IO) && addr_match;
  end

`ifdef Z80_RESP_INTACK_EN
  logic irq_in_d;
  logic irq_pending;

  assign intack = !m1_n && !iorq_n;
  assign int_n  = ~irq_pending;

  // A fresh irq_in edge beats a same-cycle acknowledge so the new request is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_in_d    <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_in_d <= irq_in;
      if (irq_in && !irq_in_d) irq_pending <= 1'b1;
      else if (intack)         irq_pending <= 1'b0;
    end
  end
`else
  logic unused_irq;

  assign intack     = 1'b0;
  assign int_n      = 1'b1;
  assign unused_irq = irq_in;
`endif

  // Acknowledge cycles are answered locally and never reach the backend.
  assign start   = hit && !intack;
  assign wait_n  = !(start && (state == IDLE || state == REQ));
  assign dout_en = (state == HOLD && !rd_n && !be_we) || intack;
  assign dout    = intack ? IRQ_VECTOR : dout_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      be_req   <= 1'b0;
      be_we    <= 1'b0;
      be_addr  <= 16'h0000;
      be_wdata <= 8'h00;
      dout_q   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            be_addr  <= A;
            be_we    <= ~wr_n;
            be_wdata <= di;
            be_req   <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (be_ack) begin
            be_req <= 1'b0;
            // Data for a cycle the CPU already abandoned is dropped.
            if (!space_n) begin
              if (!be_we) dout_q <= be_rdata;
              state <= HOLD;
            end else begin
              state <= DRAIN;
            end
          end
        end
        HOLD: begin
          if (space_n) state <= IDLE;
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/z80_bus_responder.md
Z80_BUS_RESPONDER -- requirements
Module: z80_bus_responder

Interface
REQ-001 Parameter BASE_ADDR, 16'h8000, match base address.
REQ-002 Parameter ADDR_MASK, 16'hC000, address bits that participate in the match.
REQ-003 Parameter IS_IO, 0, selects the space: 0 = memory (mreq_n, full A), 1 = I/O (iorq_n, A[7:0] only).
REQ-004 Parameter IRQ_VECTOR, 8'hFF, byte driven during interrupt acknowledge.
REQ-005 Ports SHALL be:
- clk  in  1  clock; all inputs are synchronous to clk.
- reset  in  1  asynchronous, active-high reset.
- A  in  16  CPU address.
- di  in  8  CPU write data.
- m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n  in  1 each  CPU strobes, active-low.
- dout  out  8  read data to CPU.
- dout_en  out  1  read-data valid / bus drive enable.
- wait_n  out  1  wait request to CPU, active-low.
- int_n  out  1  interrupt request to CPU, active-low.
- be_req  out  1  backend request.
- be_we  out  1  backend write flag.
- be_addr  out  16  backend address.
- be_wdata  out  8  backend write data.
- be_rdata  in  8  backend read data.
- be_ack  in  1  backend acknowledge, one-cycle pulse.
- irq_in  in  1  interrupt source, rising-edge sensitive.

Function
REQ-006 hit SHALL be high when the space strobe is low, (rd_n==0 or wr_n==0), m1_n/rfsh_n qualifiers pass (refresh excluded: rfsh_n==0 never hits; I/O: m1_n==1 required), and (addr & ADDR_MASK)==(BASE_ADDR & ADDR_MASK).
REQ-007 The FSM SHALL have four states: IDLE, REQ, HOLD, DRAIN.
REQ-008 IDLE->REQ when hit is high at a clk edge; on that edge it SHALL latch be_addr=A, be_we=~wr_n, be_wdata=di, and set be_req=1.
REQ-009 REQ: be_req SHALL stay 1 until be_ack; at the be_ack edge, be_req->0. Reads latch dout=be_rdata. Next state is HOLD if the strobe is still low, else DRAIN.
REQ-010 wait_n SHALL be combinational: 0 when hit is high and state is IDLE or REQ; 1 otherwise.
REQ-011 dout_en SHALL be combinational: 1 when state==HOLD, rd_n==0, and be_we==0.
REQ-012 HOLD->IDLE when the space strobe deasserts (goes high).
REQ-013 DRAIN (strobe released before ack, i.e. aborted cycle): SHALL go to IDLE on the next edge; read data is discarded and dout is unchanged.
REQ-014 A new hit while in HOLD or DRAIN SHALL NOT start a new request until IDLE has been re-entered.
REQ-015 be_ack received in IDLE, HOLD, or DRAIN SHALL be ignored.
REQ-016 Minimum latency: hit sampled at edge N -> be_req=1 after N; with ack at edge N+k, wait_n is released after N+k.

Reset
REQ-017 While reset is high, the block SHALL hold: state IDLE, be_req 0, be_we 0, be_addr 0, be_wdata 0, dout 0, int_n 1, irq_pending 0.
REQ-018 Consequence of REQ-017: wait_n=1 and dout_en=0 unless hit (wait_n) applies.
REQ-019 Reset during REQ SHALL abandon the backend request immediately (be_req=0); the backend tolerates request withdrawal.

Configuration
REQ-020 Macro Z80_RESP_INTACK_EN defined SHALL enable the following:
- A rising edge on irq_in sets irq_pending; int_n = ~irq_pending (registered).
- Acknowledge cycle (m1_n==0 && iorq_n==0) SHALL clear irq_pending at the next edge.
- During acknowledge, dout=IRQ_VECTOR and dout_en=1, with wait_n=1 and no backend request.
- A new irq_in edge in the same cycle as the clear SHALL win, leaving irq_pending=1.
REQ-021 Macro undefined: int_n SHALL be constant 1, irq_in is unused, and acknowledge cycles produce dout_en=0.

Verification
REQ-022 Memory read at A=16'h8123, be_ack 3 cycles after be_req, be_rdata=8'h5A -> be_addr=8123, be_we=0, wait_n low 3 cycles, dout=5A with dout_en=1 until rd_n rises.
REQ-023 Memory write A=16'hBFFF, di=8'hC3 -> be_we=1, be_wdata=C3, one be_req pulse per cycle, wait_n released after ack.
REQ-024 M1 refresh (mreq_n=0, rfsh_n=0, A=16'h8000) and a read at A=16'h4000 -> no be_req, wait_n=1 throughout.
REQ-025 Read whose strobe is released before ack (ack 5 cycles late) -> be_req held until ack, FSM passes through DRAIN, dout unchanged, no second request.
REQ-026 Z80_RESP_INTACK_EN, irq_in pulse -> int_n=0 next cycle; acknowledge cycle -> dout=FF, dout_en=1, int_n=1 after ack; without the macro int_n stays 1.
REQ-027 Assert reset mid-REQ -> be_req=0 immediately; after release, the next read completes normally.
